dcache_mem_bridge: RTL and testbench
====================================

Name: dcache_mem_bridge

Overview:
- Sits directly downstream of the L1 data cache, on its MMU-side request port.
- Converts 256-bit cache-line fill and writeback requests into 8-beat sequential 32-bit transfers on a simple word-wide memory bus.
- Passes MMIO accesses through as single-beat word transfers.
- Returns a one-cycle done pulse and holds the assembled line for the cache to latch.

Parameters:
- MMIO_MASK, 32'hF000_0000, address bits compared for MMIO decode.
- MMIO_MATCH, 32'hF000_0000, an address is MMIO when (addr & MMIO_MASK) == MMIO_MATCH.

Ports:
- sys_clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- l1_mmu_req_read  in  1  line fill request (cached) or MMIO read.
- l1_mmu_req_write  in  1  line writeback request (cached) or MMIO write.
- l1_mmu_req_addr  in  32  byte address; bits [4:0] are ignored for cached requests.
- l1_mmu_write_data  in  256  writeback line (word i = bits [32i+31:32i]); MMIO uses [31:0].
- mmu_l1_done  out  1  one-cycle completion pulse.
- mmu_l1_read_data  out  256  fill line; for MMIO, {224'b0, word}.
- mem_req  out  1  memory beat request, held until accepted.
- mem_we  out  1  beat is a write.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  beat write data.
- mem_ready  in  1  beat accepted this cycle; read data valid this cycle.
- mem_rdata  in  32  beat read data.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, beat counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mmu_l1_done=0, read-data buffer=0.
- Reset mid-burst aborts the transfer: mem_req is low from the next cycle, and no done pulse is issued.
- States: IDLE, XFER, DONE.
- IDLE:
  - Accept when req_read or req_write is high.
  - If both are high, the write is served first; the read is then seen again after done, because the cache holds it.
  - On accept, latch the address, the 256-bit write data, the op (write = req_write), and is_mmio = ((addr & MMIO_MASK) == MMIO_MATCH).
  - Next state is XFER, with mem_req=1 from the next cycle.
- XFER:
  - Cached: base = {addr[31:5], 5'b0}; beat i uses mem_addr = base + 4*i and, for writes, mem_wdata = line word i; i runs 0..7.
  - MMIO: one beat, mem_addr = {addr[31:2], 2'b00}, mem_wdata = write_data[31:0].
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ready.
  - mem_ready may arrive in the first XFER cycle; a beat completes in the same cycle its ready is sampled.
  - The next beat is presented the following cycle, with no idle gap.
  - On read-beat ready, mem_rdata is written into buffer word i (cached) or word 0 with words 1..7 cleared (MMIO).
  - After the last beat's ready, mem_req=0 and next state is DONE.
- DONE: mmu_l1_done=1 for exactly one cycle, then IDLE.
- A new request is accepted in IDLE at the earliest on the cycle after the done pulse. The cache's request lines in the done cycle are ignored.
- mmu_l1_read_data is driven from the buffer and stays stable from the done cycle until the next read beat completes. The cache writes its BRAM on the done cycle.
- Write ops do not modify the read buffer.
- Minimum cached latency (ready every cycle): accept cycle, then 8 XFER cycles, then done in cycle 10. MMIO minimum: done in cycle 3.
- Request deassertion or address change during XFER or DONE is ignored; the latched op completes.
- Addresses wrap modulo 2^32. No bursts cross a 32B line.

Test Plan:
- Cached fill: req_read, addr=0x0000_1234, mem_ready tied 1, mem_rdata = 0xA0+beat -> mem_addr sequence 0x1220..0x123C. Done one cycle in cycle 10. mmu_l1_read_data word i = 0xA0+i.
- Cached writeback with stalls: req_write, addr=0x0000_2040, line word i = 0x1111_0000+i, mem_ready low 2 cycles per beat -> each beat's addr/wdata is held while waiting, mem_we=1, eight beats at 0x2040..0x205C, one done pulse.
- MMIO read: addr=0xF000_0008, mem_rdata=0xDEAD_BEEF, ready=1 -> single beat at 0xF000_0008, done in cycle 3, read_data = {224'b0, 0xDEADBEEF}.
- Simultaneous read+write, addr=0x3000 (write) -> write burst completes with done. Read burst is accepted the cycle after done. The write never alters the buffer.
- Reset asserted at beat 4 of a fill -> mem_req=0 the next cycle, no done pulse, all outputs at reset values. A new fill afterwards starts at beat 0.
- Back-to-back: the request is held across the done cycle -> no second accept in the done cycle; the second op starts the cycle after.

Source files
------------

// File: rtl/dcache_mem_bridge.sv
// Bridge between the L1 data cache's MMU port and a word-wide memory bus.
// Cached lines move as 8 sequential 32-bit beats; MMIO moves as a single beat.
module dcache_mem_bridge #(
   parameter logic [31:0] MMIO_MASK  = 32'hF000_0000,
   parameter logic [31:0] MMIO_MATCH = 32'hF000_0000
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         l1_mmu_req_read,
   input  logic         l1_mmu_req_write,
   input  logic [31:0]  l1_mmu_req_addr,
   input  logic [255:0] l1_mmu_write_data,
   output logic         mmu_l1_done,
   output logic [255:0] mmu_l1_read_data,
   output logic         mem_req,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   input  logic         mem_ready,
   input  logic [31:0]  mem_rdata
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t           state_reg;
   logic [2:0]       beat_reg;
   logic [7:0][31:0] wline_reg;
   logic [7:0][31:0] rbuf_reg;
   logic             we_reg;
   logic             mmio_reg;

   logic             is_mmio;
   logic             last_beat;
   logic [2:0]       beat_next;

   assign is_mmio   = (l1_mmu_req_addr & MMIO_MASK) == MMIO_MATCH;
   assign last_beat = mmio_reg || (beat_reg == 3'd7);
   assign beat_next = beat_reg + 3'd1;

   for (genvar gi = 0; gi < 8; gi++) begin : g_rdata
      assign mmu_l1_read_data[32*gi +: 32] = rbuf_reg[gi];
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         beat_reg    <= 3'd0;
         wline_reg   <= '0;
         rbuf_reg    <= '0;
         we_reg      <= 1'b0;
         mmio_reg    <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'd0;
         mem_wdata   <= 32'd0;
         mmu_l1_done <= 1'b0;
      end else begin
         mmu_l1_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Write wins a tie; the cache keeps the read asserted and it is taken later.
               if (l1_mmu_req_read || l1_mmu_req_write) begin
                  state_reg <= XFER;
                  beat_reg  <= 3'd0;
                  we_reg    <= l1_mmu_req_write;
                  mmio_reg  <= is_mmio;
                  wline_reg <= l1_mmu_write_data;
                  mem_req   <= 1'b1;
                  mem_we    <= l1_mmu_req_write;
                  mem_addr  <= is_mmio ? (l1_mmu_req_addr & ~32'h3)
                                       : (l1_mmu_req_addr & ~32'h1F);
                  mem_wdata <= l1_mmu_write_data[31:0];
               end
            end
            XFER: begin
               if (mem_ready) begin
                  if (!we_reg) begin
                     if (mmio_reg)
                        rbuf_reg <= {224'b0, mem_rdata};
                     else
                        rbuf_reg[beat_reg] <= mem_rdata;
                  end
                  if (last_beat) begin
                     mem_req     <= 1'b0;
                     mem_we      <= 1'b0;
                     mmu_l1_done <= 1'b1;
                     state_reg   <= DONE;
                  end else begin
                     beat_reg  <= beat_next;
                     mem_addr  <= mem_addr + 32'd4;
                     mem_wdata <= wline_reg[beat_next];
                  end
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Self-checking bench for dcache_mem_bridge: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level beat-queue model.
module tb_dcache_mem_bridge;

   logic         sys_clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_read = 1'b0;
   logic         req_write = 1'b0;
   logic [31:0]  req_addr = 32'd0;
   logic [255:0] req_wdata = '0;
   logic         mmu_l1_done;
   logic [255:0] mmu_l1_read_data;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_ready = 1'b0;
   logic [31:0]  mem_rdata = 32'd0;

   always #5 sys_clk = ~sys_clk;

   dcache_mem_bridge dut (
      .sys_clk           (sys_clk),
      .rst_n             (rst_n),
      .l1_mmu_req_read   (req_read),
      .l1_mmu_req_write  (req_write),
      .l1_mmu_req_addr   (req_addr),
      .l1_mmu_write_data (req_wdata),
      .mmu_l1_done       (mmu_l1_done),
      .mmu_l1_read_data  (mmu_l1_read_data),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_ready         (mem_ready),
      .mem_rdata         (mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;
   int ready_mode = 0;   // 0: always ready, 1: two wait cycles per beat, 2: random
   int rdata_mode = 0;   // 0: 0xA0 + word index, 1: 0xDEADBEEF, 2: random

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (mem_req) begin
            case (ready_mode)
               0: mem_ready = 1'b1;
               1: begin
                  if (wait_cnt >= 2) begin
                     mem_ready = 1'b1;
                     wait_cnt  = 0;
                  end else begin
                     mem_ready = 1'b0;
                     wait_cnt++;
                  end
               end
               default: mem_ready = ($urandom_range(0, 2) != 0);
            endcase
         end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
         end
         case (rdata_mode)
            0:       mem_rdata = 32'hA0 + {29'b0, mem_addr[4:2]};
            1:       mem_rdata = 32'hDEAD_BEEF;
            default: mem_rdata = $urandom();
         endcase
      end
   end

   // Reference model: a queue of pending beats plus the line the cache should see.
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [2:0]  idx;
      logic        mmio;
   } beat_t;

   beat_t        q[$];
   logic [255:0] m_buf  = '0;
   bit           m_done = 1'b0;

   initial begin
      beat_t       b;
      logic        mmio;
      logic [31:0] base;
      int          cnt;
      forever begin
         @(negedge sys_clk);
         if (check_en) begin
            check("mem_req", mem_req, q.size() != 0);
            check("done", mmu_l1_done, m_done);
            check("read_data", mmu_l1_read_data, m_buf);
            if (q.size() != 0) begin
               check("mem_addr", mem_addr, q[0].addr);
               check("mem_we", mem_we, q[0].we);
               if (q[0].we) check("mem_wdata", mem_wdata, q[0].wdata);
            end
         end
         // Advance with the inputs the DUT samples at the coming posedge.
         if (!rst_n) begin
            q.delete();
            m_done = 1'b0;
            m_buf  = '0;
         end else if (m_done) begin
            m_done = 1'b0;
         end else if (q.size() != 0) begin
            if (mem_ready) begin
               b = q.pop_front();
               if (!b.we) begin
                  if (b.mmio) m_buf = {224'b0, mem_rdata};
                  else        m_buf[32*b.idx +: 32] = mem_rdata;
               end
               if (q.size() == 0) m_done = 1'b1;
            end
         end else if (req_read || req_write) begin
            mmio = (req_addr[31:28] == 4'hF);
            cnt  = mmio ? 1 : 8;
            base = mmio ? {req_addr[31:2], 2'b00} : {req_addr[31:5], 5'b0};
            for (int i = 0; i < cnt; i++) begin
               b.addr  = base + 32'(4 * i);
               b.we    = req_write;
               b.wdata = req_wdata[32*i +: 32];
               b.idx   = 3'(i);
               b.mmio  = mmio;
               q.push_back(b);
            end
         end
      end
   end

   // Presents a request from the next cycle (cycle 1) and waits for done;
   // returns the cycle number of the done pulse with the request still asserted.
   task automatic op(input logic r, input logic w, input logic [31:0] a,
                     input logic [255:0] line, output int cyc, output logic [31:0] first_addr);
      bit got;
      got = 1'b0;
      first_addr = 32'hFFFF_FFFF;
      @(posedge sys_clk);
      #1;
      req_read  = r;
      req_write = w;
      req_addr  = a;
      req_wdata = line;
      cyc = 1;
      forever begin
         @(negedge sys_clk);
         if (!got && mem_req) begin
            first_addr = mem_addr;
            got = 1'b1;
         end
         if (mmu_l1_done === 1'b1) break;
         cyc++;
         if (cyc > 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: got no done after %0d cycles, required a done pulse", cyc);
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      @(posedge sys_clk);
      #1;
      req_read  = 1'b0;
      req_write = 1'b0;
      repeat (n) @(posedge sys_clk);
   endtask

   initial begin
      int           cyc;
      logic [31:0]  fa;
      logic [255:0] fill_a0;
      logic [255:0] line;
      logic         r, w;
      logic [31:0]  a;

      for (int i = 0; i < 8; i++) fill_a0[32*i +: 32] = 32'hA0 + 32'(i);

      repeat (3) @(posedge sys_clk);
      #1;
      rst_n    = 1'b1;
      check_en = 1'b1;
      @(negedge sys_clk);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_read_data", mmu_l1_read_data, 256'd0);

      // Cached fill, ready every cycle
      ready_mode = 0;
      rdata_mode = 0;
      op(1'b1, 1'b0, 32'h0000_1234, '0, cyc, fa);
      check("fill_latency", cyc, 10);
      check("fill_first_addr", fa, 32'h0000_1220);
      check("fill_line", mmu_l1_read_data, fill_a0);
      idle(2);

      // Cached writeback, two wait cycles per beat
      ready_mode = 1;
      for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h1111_0000 + 32'(i);
      op(1'b0, 1'b1, 32'h0000_2040, line, cyc, fa);
      check("wb_latency", cyc, 26);
      check("wb_first_addr", fa, 32'h0000_2040);
      check("wb_keeps_buffer", mmu_l1_read_data, fill_a0);
      idle(2);

      // MMIO read
      ready_mode = 0;
      rdata_mode = 1;
      op(1'b1, 1'b0, 32'hF000_0008, {8{32'h5555_AAAA}}, cyc, fa);
      check("mmio_latency", cyc, 3);
      check("mmio_addr", fa, 32'hF000_0008);
      check("mmio_data", mmu_l1_read_data, {224'b0, 32'hDEAD_BEEF});
      idle(2);

      // Simultaneous read and write: write first, read accepted the cycle after done
      rdata_mode = 0;
      for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h3300_0000 + 32'(i);
      op(1'b1, 1'b1, 32'h0000_3000, line, cyc, fa);
      check("rw_write_latency", cyc, 10);
      check("rw_write_keeps_buffer", mmu_l1_read_data, {224'b0, 32'hDEAD_BEEF});
      op(1'b1, 1'b0, 32'h0000_3000, line, cyc, fa);
      check("rw_read_latency", cyc, 10);
      check("rw_read_line", mmu_l1_read_data, fill_a0);
      idle(2);

      // Reset while beat 4 of a fill is on the bus
      @(posedge sys_clk);
      #1;
      req_read = 1'b1;
      req_addr = 32'h0000_4000;
      repeat (5) @(posedge sys_clk);
      #1;
      rst_n    = 1'b0;
      req_read = 1'b0;
      @(negedge sys_clk);
      check("pre_rst_beat4_addr", mem_addr, 32'h0000_4010);
      @(negedge sys_clk);
      check("abort_mem_req", mem_req, 1'b0);
      check("abort_done", mmu_l1_done, 1'b0);
      check("abort_mem_addr", mem_addr, 32'd0);
      check("abort_mem_we", mem_we, 1'b0);
      check("abort_mem_wdata", mem_wdata, 32'd0);
      check("abort_read_data", mmu_l1_read_data, 256'd0);
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      op(1'b1, 1'b0, 32'h0000_4000, '0, cyc, fa);
      check("after_rst_latency", cyc, 10);
      check("after_rst_first_addr", fa, 32'h0000_4000);
      idle(1);

      // Back-to-back: request held across the done cycle
      op(1'b1, 1'b0, 32'h0000_5020, '0, cyc, fa);
      op(1'b1, 1'b0, 32'h0000_5020, '0, cyc, fa);
      check("b2b_latency", cyc, 10);
      idle(1);

      // Randomized traffic
      ready_mode = 2;
      rdata_mode = 2;
      repeat (40) begin
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         if (!r && !w) r = 1'b1;
         a = $urandom();
         if ($urandom_range(0, 3) == 0) a[31:28] = 4'hF;
         else                           a[31]    = 1'b0;
         for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom();
         op(r, w, a, line, cyc, fa);
         if (r && w) op(1'b1, 1'b0, a, line, cyc, fa);
         idle($urandom_range(0, 2));
      end

      repeat (3) @(posedge sys_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
